// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu
//  Description : Load/store unit between core datapath and byte-lane data bus;
//                stalls the core while an access is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_SZ_B  = 3'd0;
  localparam logic [2:0] c_SZ_H  = 3'd1;
  localparam logic [2:0] c_SZ_W  = 3'd2;
  localparam logic [2:0] c_SZ_BU = 3'd4;
  localparam logic [2:0] c_SZ_HU = 3'd5;

  localparam int              c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [2:0]        r_size;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wd;
  logic [c_CW-1:0]   r_cnt;
  logic [31:0]       r_rd;
  logic              r_err;

  logic              w_legal;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_data;
  logic              w_timeout;
  logic              w_busy;

  // Legality check and store lane steering, from the live core request.
  always_comb begin
    w_off   = core_addr_i[1:0];
    w_legal = 1'b0;
    w_be    = 4'b1111;
    w_wd    = core_wd_i;
    case (core_size_i)
      c_SZ_B, c_SZ_BU: begin
        w_legal = 1'b1;
        if (core_we_i) begin
          w_be = 4'b0001 << w_off;
          w_wd = {4{core_wd_i[7:0]}};
        end
      end
      c_SZ_H, c_SZ_HU: begin
        w_legal = ~w_off[0];
        if (core_we_i) begin
          w_be = 4'b0011 << w_off;
          w_wd = {2{core_wd_i[15:0]}};
        end
      end
      c_SZ_W:  w_legal = (w_off == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Load data extraction from the returned word, using the latched offset.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rd_i[7:0];
      2'd1:    w_byte = mem_rd_i[15:8];
      2'd2:    w_byte = mem_rd_i[23:16];
      default: w_byte = mem_rd_i[31:24];
    endcase
    w_half = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (r_size)
      c_SZ_B:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      c_SZ_BU: w_ld_data = {24'd0, w_byte};
      c_SZ_H:  w_ld_data = {{16{w_half[15]}}, w_half};
      c_SZ_HU: w_ld_data = {16'd0, w_half};
      default: w_ld_data = mem_rd_i;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TMO_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    core_stall_req_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (core_req_i && w_legal) begin
          w_state_nxt      = ST_BUSY;
          core_stall_req_o = 1'b1;
        end
      end
      ST_BUSY: begin
        core_stall_req_o = 1'b1;
        if (mem_ready_i || w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wd    <= 32'd0;
      r_cnt   <= '0;
      r_rd    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (core_req_i) begin
            if (w_legal) begin
              r_we   <= core_we_i;
              r_size <= core_size_i;
              r_addr <= core_addr_i;
              r_be   <= w_be;
              r_wd   <= w_wd;
              r_cnt  <= '0;
            end else begin
              r_err <= 1'b1;
              r_rd  <= 32'd0;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          // A ready in the final wait cycle still wins over the timeout.
          if (mem_ready_i) begin
            if (!r_we) begin
              r_rd <= w_ld_data;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_rd  <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_busy     = (r_state == ST_BUSY);
  assign mem_req_o  = w_busy;
  assign mem_we_o   = w_busy & r_we;
  assign mem_be_o   = w_busy ? r_be : 4'd0;
  assign mem_addr_o = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wd_o   = w_busy ? r_wd : 32'd0;
  assign core_rd_o  = r_rd;
  assign core_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_lsu
//  Description : Scoreboard bench for riscv_lsu with a wait-state memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

  localparam int c_TMO = 16;

  logic        clk;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu #(.TIMEOUT(c_TMO)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_size_i      (core_size_i),
    .core_addr_i      (core_addr_i),
    .core_wd_i        (core_wd_i),
    .core_rd_o        (core_rd_o),
    .core_stall_req_o (core_stall_req_o),
    .core_err_o       (core_err_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wd_o         (mem_wd_o),
    .mem_rd_i         (mem_rd_i),
    .mem_ready_i      (mem_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wait_cfg = 0;
  logic [31:0] rd_cfg = 32'd0;
  logic        done_flag = 1'b0;
  logic        mon_en = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return addr[0] == 1'b0;
      3'd2:       return addr[1:0] == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] size, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] w;
    w = word >> (8 * addr[1:0]);
    case (size)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return word;
    endcase
  endfunction

  // Memory model: ready after wait_cfg request cycles; ready is also held
  // high with junk data whenever no request is pending.
  initial begin
    int bcnt;
    bcnt        = 0;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        mem_ready_i = (bcnt == wait_cfg);
        mem_rd_i    = rd_cfg;
        bcnt++;
      end else begin
        bcnt        = 0;
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'hA5A5_A5A5;
      end
    end
  end

  // Monitor: counts stall/request cycles and retires scoreboard entries.
  initial begin
    int   stall_cnt;
    int   req_cnt;
    logic prev_stall;
    exp_t e;
    stall_cnt  = 0;
    req_cnt    = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin
        stall_cnt  = 0;
        req_cnt    = 0;
        prev_stall = 1'b0;
      end else if (mon_en) begin
        if (core_stall_req_o) stall_cnt++;
        if (mem_req_o) begin
          req_cnt++;
          check_val("sb_has_req", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q[0];
            check_val("mem_we", 32'(mem_we_o), 32'(e.we));
            check_val("mem_be", 32'(mem_be_o), 32'(e.be));
            check_val("mem_addr", mem_addr_o, e.addr);
            if (e.we) check_val("mem_wd", mem_wd_o, e.wd);
          end
        end
        if (core_err_o || (prev_stall && !core_stall_req_o)) begin
          check_val("sb_has_done", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("err", 32'(core_err_o), 32'(e.err));
            check_val("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            check_val("req_cycles", 32'(req_cnt), 32'(e.reqs));
            if (e.reqs != 0 && (!e.we || e.err)) check_val("core_rd", core_rd_o, e.rd);
          end
          stall_cnt = 0;
          req_cnt   = 0;
          done_flag = 1'b1;
        end
        prev_stall = core_stall_req_o;
      end
    end
  end

  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] mrd, input int waitn,
                            input logic tmo);
    exp_t e;
    logic legal;
    legal  = is_legal(size, addr);
    e.we   = we;
    e.addr = {addr[31:2], 2'b00};
    e.be   = 4'hF;
    e.wd   = wd;
    if (we && (size == 3'd0 || size == 3'd4)) begin
      e.be = 4'h1 << addr[1:0];
      e.wd = {24'd0, wd[7:0]} * 32'h0101_0101;
    end else if (we && (size == 3'd1 || size == 3'd5)) begin
      e.be = 4'h3 << addr[1:0];
      e.wd = {16'd0, wd[15:0]} * 32'h0001_0001;
    end
    if (!legal) begin
      e.err = 1'b1; e.stalls = 0; e.reqs = 0; e.rd = 32'd0;
    end else if (tmo) begin
      e.err = 1'b1; e.stalls = c_TMO + 1; e.reqs = c_TMO; e.rd = 32'd0;
    end else begin
      e.err = 1'b0; e.stalls = waitn + 2; e.reqs = waitn + 1; e.rd = exp_load(size, addr, mrd);
    end
    wait_cfg = tmo ? 1000 : waitn;
    rd_cfg   = mrd;
    @(negedge clk);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    done_flag   = 1'b0;
    sb_q.push_back(e);
    if (!legal) begin
      @(negedge clk);
      core_req_i = 1'b0;
    end
    for (int i = 0; i < 60 && !done_flag; i++) @(negedge clk);
    core_req_i = 1'b0;
    check_val("done_seen", 32'(done_flag), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'd0;
    core_wd_i   = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_rd", core_rd_o, 32'd0);
    check_val("rst_err", 32'(core_err_o), 32'd0);
    check_val("rst_req", 32'(mem_req_o), 32'd0);
    check_val("rst_bus", {mem_be_o, mem_we_o, 27'd0} | mem_addr_o | mem_wd_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    run_access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);  // LW
    run_access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0);  // LB
    run_access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0);  // LBU
    run_access(1'b0, 3'd5, 32'h102, 32'd0, 32'h80FF_0000, 0, 1'b0);  // LHU
    run_access(1'b0, 3'd1, 32'h102, 32'd0, 32'h80FF_0000, 2, 1'b0);  // LH
    run_access(1'b0, 3'd4, 32'h101, 32'd0, 32'h1234_C678, 1, 1'b0);  // LBU off 1
    run_access(1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'd0, 0, 1'b0);  // SB
    run_access(1'b1, 3'd1, 32'h202, 32'h1234_5678, 32'd0, 0, 1'b0);  // SH
    run_access(1'b1, 3'd2, 32'h204, 32'h1234_5678, 32'd0, 4, 1'b0);  // SW, 6 stalls
    run_access(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 1'b0);          // misaligned LW
    run_access(1'b0, 3'd1, 32'h103, 32'd0, 32'd0, 0, 1'b0);          // misaligned LH
    run_access(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 1'b0);          // bad size
    run_access(1'b0, 3'd2, 32'h300, 32'd0, 32'hCAFE_F00D, 0, 1'b0);  // LW, rd nonzero

    // Reset during the second BUSY cycle of a pending load.
    mon_en   = 1'b0;
    wait_cfg = 1000;
    @(negedge clk);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h400;
    @(negedge clk);
    @(negedge clk);
    rst_i      = 1'b1;
    core_req_i = 1'b0;
    @(negedge clk);
    #2;
    check_val("midrst_req", 32'(mem_req_o), 32'd0);
    check_val("midrst_stall", 32'(core_stall_req_o), 32'd0);
    check_val("midrst_rd", core_rd_o, 32'd0);
    check_val("midrst_err", 32'(core_err_o), 32'd0);
    check_val("midrst_bus", {mem_be_o, mem_we_o, 27'd0} | mem_addr_o | mem_wd_o, 32'd0);
    @(negedge clk);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run_access(1'b1, 3'd2, 32'h500, 32'hAAAA_5555, 32'd0, 0, 1'b1);  // store timeout
    run_access(1'b0, 3'd0, 32'h600, 32'd0, 32'h0000_007F, 0, 1'b0);  // LB recovers

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
